// File: rtl/julia_frame_renderer.sv
// Escape-time Julia set renderer. It packs four 8-bit iteration counts per word and writes them to the SDRAM controller.
// Optional JULIA_RUNTIME_C_EN: adds c_re/c_im inputs, which are latched when a frame starts.
//
// state | meaning
// IDLE  | waiting for start after reset
// LOAD  | z <- current pixel coordinate, iter <- 0
// ITER  | one z <- z^2 + c step or escape test per cycle
// PACK  | drop iteration byte into its lane, advance pixel
// WRITE | word presented to controller until data_write_done
// DONE  | frame complete, waiting for next start
module julia_frame_renderer #(
  parameter int H_RES     = 800,
  parameter int V_RES     = 480,
  parameter int MAX_ITER  = 255,
  parameter int WIDTH     = 16,
  parameter int FRAC_BITS = 12,
  parameter int X_START   = -8192,
  parameter int Y_START   = 4800,
  parameter int STEP      = 20,
  parameter int C_RE      = -3277,
  parameter int C_IM      = 639
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
`ifdef JULIA_RUNTIME_C_EN
  input  logic signed [WIDTH-1:0] c_re,
  input  logic signed [WIDTH-1:0] c_im,
`endif
  output logic                    busy,
  output logic                    frame_done,
  output logic [1:0]              command,
  output logic [21:0]             data_address,
  output logic [31:0]             data_write,
  input  logic                    data_write_done
);

  localparam int WORDS = H_RES * V_RES / 4;
  localparam int XW    = $clog2(H_RES + 1);
  localparam int PW    = 2 * WIDTH;
  localparam int MW    = 2 * WIDTH + 1;
  localparam logic signed [MW-1:0] ESC_LIM = MW'(4) << (2 * FRAC_BITS);

  typedef enum logic [2:0] {IDLE, LOAD, ITER, PACK, WRITE, DONE} state_t;

  state_t state, state_next;

  logic [XW-1:0]           x;
  logic signed [WIDTH-1:0] re, im, zr, zi;
  logic [7:0]              iter;
  logic signed [WIDTH-1:0] cr_use, ci_use;
  logic signed [PW-1:0]    zr2, zi2, zrzi;
  logic signed [MW-1:0]    mag, diff, dbl;
  logic signed [WIDTH-1:0] zr_next, zi_next;
  logic                    escape, last_word, line_end;

`ifdef JULIA_RUNTIME_C_EN
  logic signed [WIDTH-1:0] cr_q, ci_q;
  assign cr_use = cr_q;
  assign ci_use = ci_q;
`else
  assign cr_use = WIDTH'(C_RE);
  assign ci_use = WIDTH'(C_IM);
`endif

  // Products and the escape sum are kept at full width, so the bailout test cannot overflow.
  assign zr2     = PW'(zr) * PW'(zr);
  assign zi2     = PW'(zi) * PW'(zi);
  assign zrzi    = PW'(zr) * PW'(zi);
  assign mag     = MW'(zr2) + MW'(zi2);
  assign diff    = MW'(zr2) - MW'(zi2);
  assign dbl     = MW'(zrzi) <<< 1;
  assign zr_next = WIDTH'(diff >>> FRAC_BITS) + cr_use;
  assign zi_next = WIDTH'(dbl >>> FRAC_BITS) + ci_use;
  assign escape  = (mag > ESC_LIM) || (iter == 8'(MAX_ITER));

  assign last_word = (data_address == 22'(WORDS - 1));
  assign line_end  = (x == XW'(H_RES - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = LOAD;
      LOAD:       state_next = ITER;
      ITER:       if (escape) state_next = PACK;
      PACK:       state_next = (x[1:0] == 2'd3) ? WRITE : LOAD;
      WRITE:      if (data_write_done) state_next = last_word ? DONE : LOAD;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      command      <= 2'd0;
      data_address <= '0;
      data_write   <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      x            <= '0;
      re           <= '0;
      im           <= '0;
      zr           <= '0;
      zi           <= '0;
      iter         <= '0;
`ifdef JULIA_RUNTIME_C_EN
      cr_q         <= '0;
      ci_q         <= '0;
`endif
    end else begin
      state      <= state_next;
      command    <= (state_next == WRITE) ? 2'd1 : 2'd0;
      frame_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x            <= '0;
            data_address <= '0;
            re           <= WIDTH'(X_START);
            im           <= WIDTH'(Y_START);
            busy         <= 1'b1;
`ifdef JULIA_RUNTIME_C_EN
            cr_q         <= c_re;
            ci_q         <= c_im;
`endif
          end
        end
        LOAD: begin
          zr   <= re;
          zi   <= im;
          iter <= '0;
        end
        ITER: begin
          if (!escape) begin
            zr   <= zr_next;
            zi   <= zi_next;
            iter <= iter + 8'd1;
          end
        end
        PACK: begin
          data_write[{x[1:0], 3'b000} +: 8] <= iter;
          if (line_end) begin
            x  <= '0;
            re <= WIDTH'(X_START);
            im <= im - WIDTH'(STEP);
          end else begin
            x  <= x + XW'(1);
            re <= re + WIDTH'(STEP);
          end
        end
        WRITE: begin
          if (data_write_done) begin
            if (last_word) begin
              data_address <= '0;
              frame_done   <= 1'b1;
              busy         <= 1'b0;
            end else begin
              data_address <= data_address + 22'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_julia_frame_renderer.sv
// Bench for julia_frame_renderer. It uses three small-frame instances with hand-computed pixel words.
// Rows in the vector table describe one write each: address, data, start-to-write latency and stall length.
module tb_julia_frame_renderer;

  logic        clk = 1'b0;
  logic        start   [3];
  logic        reset   [3];
  logic        done_in [3];
  logic        busy    [3];
  logic        fdone   [3];
  logic [1:0]  cmd     [3];
  logic [21:0] addr    [3];
  logic [31:0] wdata   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // u0: z0 = 0 and c = 0 never escape, so every pixel hits MAX_ITER.
  julia_frame_renderer #(.H_RES(4), .V_RES(1), .X_START(0), .Y_START(0), .STEP(0),
                         .C_RE(0), .C_IM(0)) u0 (
    .clk(clk), .reset(reset[0]), .start(start[0]),
`ifdef JULIA_RUNTIME_C_EN
    .c_re(16'sd0), .c_im(16'sd0),
`endif
    .busy(busy[0]), .frame_done(fdone[0]), .command(cmd[0]),
    .data_address(addr[0]), .data_write(wdata[0]), .data_write_done(done_in[0]));

  // u1: z0 = 3.0 escapes on the first test, so every pixel has iter 0.
  julia_frame_renderer #(.H_RES(8), .V_RES(2), .X_START(12288), .STEP(0)) u1 (
    .clk(clk), .reset(reset[1]), .start(start[1]),
`ifdef JULIA_RUNTIME_C_EN
    .c_re(16'sd0), .c_im(16'sd0),
`endif
    .busy(busy[1]), .frame_done(fdone[1]), .command(cmd[1]),
    .data_address(addr[1]), .data_write(wdata[1]), .data_write_done(done_in[1]));

  // u2: real-axis pixels 5000, 6500, 8000 and 9500 with c = 0 give iterations 2, 1, 1 and 0.
  julia_frame_renderer #(.H_RES(4), .V_RES(1), .X_START(5000), .Y_START(0), .STEP(1500),
                         .C_RE(0), .C_IM(0)) u2 (
    .clk(clk), .reset(reset[2]), .start(start[2]),
`ifdef JULIA_RUNTIME_C_EN
    .c_re(16'sd0), .c_im(16'sd0),
`endif
    .busy(busy[2]), .frame_done(fdone[2]), .command(cmd[2]),
    .data_address(addr[2]), .data_write(wdata[2]), .data_write_done(done_in[2]));

  typedef struct {
    int          dut;
    bit          go;
    int          lat;
    int          hold;
    bit          glitch;
    bit          last;
    logic [21:0] ea;
    logic [31:0] ed;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cmd(input int d, input bit go, input bit glitch, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    start[d] = go;
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      start[d]   = glitch && (n == 3);
      done_in[d] = glitch && (n == 3);
      if (cmd[d] == 2'd1) seen = 1'b1;
    end
    start[d]   = 1'b0;
    done_in[d] = 1'b0;
    chk("write_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    vec_t        v;
    int          d, n, errs;
    bit          seen;
    logic [21:0] a0;
    logic [31:0] d0;

    // Row fields: dut, go, lat, hold, glitch, last, expected address, expected data.
    vecs[0] = '{1, 1'b1, 13,  0, 1'b0, 1'b0, 22'd0, 32'h0000_0000};
    vecs[1] = '{1, 1'b0, 12, 50, 1'b1, 1'b0, 22'd1, 32'h0000_0000};
    vecs[2] = '{1, 1'b0, 12,  0, 1'b0, 1'b0, 22'd2, 32'h0000_0000};
    vecs[3] = '{1, 1'b0, 12,  3, 1'b0, 1'b1, 22'd3, 32'h0000_0000};
    vecs[4] = '{1, 1'b1, 13,  0, 1'b0, 1'b0, 22'd0, 32'h0000_0000};
    vecs[5] = '{1, 1'b0, 12,  1, 1'b0, 1'b0, 22'd1, 32'h0000_0000};
    vecs[6] = '{1, 1'b0, 12,  0, 1'b0, 1'b0, 22'd2, 32'h0000_0000};
    vecs[7] = '{1, 1'b0, 12,  0, 1'b0, 1'b1, 22'd3, 32'h0000_0000};
    vecs[8] = '{0, 1'b1, 1033, 0, 1'b0, 1'b1, 22'd0, 32'hFFFF_FFFF};
    vecs[9] = '{2, 1'b1, 17,  2, 1'b0, 1'b1, 22'd0, 32'h0001_0102};

    for (int i = 0; i < 3; i++) begin
      start[i]   = 1'b0;
      reset[i]   = 1'b1;
      done_in[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_command", 32'(cmd[i]), 32'd0);
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_frame_done", 32'(fdone[i]), 32'd0);
      chk("rst_address", 32'(addr[i]), 32'd0);
    end
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (cmd[1] != 2'd0 || busy[1]) errs++;
    end
    chk("no_write_without_start", 32'(errs), 32'd0);

    // Reset while a write is pending must drop command on the next edge.
    wait_cmd(1, 1'b1, 1'b0, seen, n);
    chk("pre_reset_address", 32'(addr[1]), 32'd0);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk("reset_mid_write_command", 32'(cmd[1]), 32'd0);
    chk("reset_mid_write_busy", 32'(busy[1]), 32'd0);
    chk("reset_mid_write_address", 32'(addr[1]), 32'd0);

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      d = v.dut;
      wait_cmd(d, v.go, v.glitch, seen, n);
      if (seen) begin
        chk("latency", 32'(n), 32'(v.lat));
        chk("address", 32'(addr[d]), 32'(v.ea));
        chk("data", wdata[d], v.ed);
        chk("busy_in_write", 32'(busy[d]), 32'd1);
        a0 = addr[d];
        d0 = wdata[d];
        errs = 0;
        repeat (v.hold) begin
          @(negedge clk);
          if (cmd[d] != 2'd1 || addr[d] != a0 || wdata[d] != d0) errs++;
        end
        chk("stall_stable", 32'(errs), 32'd0);
        done_in[d] = 1'b1;
        @(negedge clk);
        done_in[d] = 1'b0;
        chk("command_after_done", 32'(cmd[d]), 32'd0);
        if (v.last) begin
          chk("frame_done_pulse", 32'(fdone[d]), 32'd1);
          chk("busy_cleared", 32'(busy[d]), 32'd0);
          chk("address_wrapped", 32'(addr[d]), 32'd0);
          errs = 0;
          repeat (5) begin
            @(negedge clk);
            if (fdone[d] || cmd[d] != 2'd0 || busy[d]) errs++;
          end
          chk("done_idle", 32'(errs), 32'd0);
        end else begin
          chk("no_early_frame_done", 32'(fdone[d]), 32'd0);
          chk("address_increment", 32'(addr[d]), 32'(v.ea) + 32'd1);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
